// File: rtl/pc_fetch.sv
// Program counter and fetch stage feeding the decoder from the bios instruction ROM.
// Latency: the ROM word at address A appears on instruction_out one posedge after end_c = A.
// Backpressure: stall_in freezes pc, IR and valid. A redirect wins over a stall and costs one bubble.
//
// Ports
//   clock_in, reset_in             single clock; synchronous active-high reset
//   stall_in                       hold pc, IR, pc_out and valid this cycle
//   halt_in                        decoder reports a halt instruction in the IR (only acted on when valid_out=1)
//   jump_en_in / jump_addr_in      unconditional redirect (highest priority redirect)
//   branch_en_in / branch_cond_in  conditional redirect to branch_addr_in, taken when cond=1
//   branch_addr_in
//   instruction_in                 ROM word at end_c (combinational from ROM)
//   end_c                          ROM read address (the pc register)
//   instruction_out / pc_out       instruction register and the address it was fetched from
//   valid_out                      IR holds a live instruction
//   halted_out                     fetch stopped in HALT (left only by reset)
//   error_out                      address bound violation; constant 0 unless PC_BOUND_CHECK_EN is defined
//
// Configuration macro: PC_BOUND_CHECK_EN
//   defined   : any next fetch address above max_addr halts the stage with error_out=1
//   undefined : no check; addresses wrap modulo 2**memory_size
//
// The ROM samples end_c on the negedge. end_c is a posedge register, so the address
// is stable for half a cycle before the ROM uses it.

module pc_fetch #(
    parameter int unsigned data_size   = 32,
    parameter int unsigned memory_size = 11,
    parameter int unsigned reset_addr  = 0,
    parameter int unsigned max_addr    = 100
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   stall_in,
    input  logic                   halt_in,
    input  logic                   jump_en_in,
    input  logic [memory_size-1:0] jump_addr_in,
    input  logic                   branch_en_in,
    input  logic                   branch_cond_in,
    input  logic [memory_size-1:0] branch_addr_in,
    input  logic [data_size-1:0]   instruction_in,
    output logic [memory_size-1:0] end_c,
    output logic [data_size-1:0]   instruction_out,
    output logic [memory_size-1:0] pc_out,
    output logic                   valid_out,
    output logic                   halted_out,
    output logic                   error_out
);

    localparam logic [memory_size-1:0] RESET_PC = memory_size'(reset_addr);
    localparam logic [memory_size-1:0] PC_ONE   = memory_size'(1);

    // max_addr has to be representable as an address; otherwise the bound
    // check could never fire and the configuration is almost certainly wrong.
    if (max_addr > ((1 << memory_size) - 1)) begin : g_max_addr_range
        $error("pc_fetch: max_addr does not fit in memory_size bits");
    end

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                 state_q,  state_d;
    logic [memory_size-1:0] pc_q,     pc_d;
    logic [data_size-1:0]   ir_q,     ir_d;
    logic [memory_size-1:0] pc_out_q, pc_out_d;
    logic                   valid_q,  valid_d;
`ifdef PC_BOUND_CHECK_EN
    logic                   error_q,  error_d;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                   redirect;    // jump, or taken branch
    logic [memory_size-1:0] target;      // redirect target, jump has priority
    logic [memory_size-1:0] seq_pc;      // sequential next address, wraps naturally
    logic [memory_size-1:0] next_fetch;  // the address end_c would move to this cycle
    logic                   advance;     // end_c would change this cycle
    logic                   halt_take;   // halt only counts against a live instruction
    logic                   bound_err;

    always_comb begin : req_decode
        redirect   = jump_en_in | (branch_en_in & branch_cond_in);
        target     = jump_en_in ? jump_addr_in : branch_addr_in;
        seq_pc     = pc_q + PC_ONE;
        next_fetch = redirect ? target : seq_pc;
        advance    = redirect | ~stall_in;
        halt_take  = halt_in & valid_q;
`ifdef PC_BOUND_CHECK_EN
        // Extend by one bit so the compare is unsigned and width-matched.
        bound_err  = advance & ({1'b0, next_fetch} > (memory_size + 1)'(max_addr));
`else
        bound_err  = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // FSM process 1: state and datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin : state_reg
        if (reset_in) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
`ifdef PC_BOUND_CHECK_EN
            error_q  <= error_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and datapath
    // Priority inside RUN: halt > bound error > redirect > stall > sequential.
    // ------------------------------------------------------------------
    always_comb begin : next_state
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
`ifdef PC_BOUND_CHECK_EN
        error_d  = error_q;
`endif

        case (state_q)
            ST_RUN: begin
                if (halt_take) begin
                    // Everything freezes where it is; only valid drops.
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (bound_err) begin
                    // Do not move to the illegal address; stop instead.
                    state_d = ST_HALT;
                    valid_d = 1'b0;
`ifdef PC_BOUND_CHECK_EN
                    error_d = 1'b1;
`endif
                end else if (redirect) begin
                    // The word currently on instruction_in is wrong-path:
                    // leave the IR alone and insert one bubble.
                    pc_d    = next_fetch;
                    valid_d = 1'b0;
                end else if (!stall_in) begin
                    pc_d     = next_fetch;
                    ir_d     = instruction_in;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                end
            end
            ST_HALT: begin
                // Only reset leaves HALT; all requests are ignored.
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin : fsm_out
        halted_out = (state_q == ST_HALT);
    end

    assign end_c           = pc_q;
    assign instruction_out = ir_q;
    assign pc_out          = pc_out_q;
    assign valid_out       = valid_q;
`ifdef PC_BOUND_CHECK_EN
    assign error_out       = error_q;
`else
    assign error_out       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a scoreboard of expected per-cycle state.
// Stimulus pushes the hand-computed expectation for the cycle it drives; the
// monitor pops one entry after each posedge and compares it with the outputs.

module tb_pc_fetch;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          stall_in;
    logic          halt_in;
    logic          jump_en_in;
    logic [AW-1:0] jump_addr_in;
    logic          branch_en_in;
    logic          branch_cond_in;
    logic [AW-1:0] branch_addr_in;
    logic [DW-1:0] instruction_in;
    logic [AW-1:0] end_c;
    logic [DW-1:0] instruction_out;
    logic [AW-1:0] pc_out;
    logic          valid_out;
    logic          halted_out;
    logic          error_out;

    always #5 clock_in = ~clock_in;

    pc_fetch #(
        .data_size   (DW),
        .memory_size (AW),
        .reset_addr  (0),
        .max_addr    (100)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .stall_in        (stall_in),
        .halt_in         (halt_in),
        .jump_en_in      (jump_en_in),
        .jump_addr_in    (jump_addr_in),
        .branch_en_in    (branch_en_in),
        .branch_cond_in  (branch_cond_in),
        .branch_addr_in  (branch_addr_in),
        .instruction_in  (instruction_in),
        .end_c           (end_c),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .halted_out      (halted_out),
        .error_out       (error_out)
    );

    // ROM contents: tag byte plus the address, so every word differs and none is zero.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {8'hC3, 13'd0, a};
    endfunction

    assign instruction_in = rom_word(end_c);

    typedef struct {
        int            id;
        logic [AW-1:0] endc;
        logic          vld;
        logic [AW-1:0] pc;
        logic          irz;   // IR still holds its reset value 0
        logic          hlt;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step %0d: got %h, required %h", name, id, act, req);
        end
    endtask

    // One clock of stimulus plus the state expected right after the next posedge.
    task automatic cyc(input logic rst, input logic stall, input logic halt,
                       input logic jen, input int ja,
                       input logic ben, input logic bc, input int ba,
                       input int e_endc, input logic e_vld, input int e_pc,
                       input logic e_irz, input logic e_hlt, input logic e_err);
        exp_t e;
        @(negedge clock_in);
        reset_in       = rst;
        stall_in       = stall;
        halt_in        = halt;
        jump_en_in     = jen;
        jump_addr_in   = AW'(ja);
        branch_en_in   = ben;
        branch_cond_in = bc;
        branch_addr_in = AW'(ba);
        e.id   = step_no;
        e.endc = AW'(e_endc);
        e.vld  = e_vld;
        e.pc   = AW'(e_pc);
        e.irz  = e_irz;
        e.hlt  = e_hlt;
        e.err  = e_err;
        exp_q.push_back(e);
        step_no++;
    endtask

    // Monitor: one expectation per posedge, sampled 1 time unit after the edge.
    initial begin : monitor
        forever begin : mon_loop
            exp_t e;
            logic [DW-1:0] exp_ir;
            @(posedge clock_in);
            #1;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                exp_ir = e.irz ? '0 : rom_word(e.pc);
                chk("end_c",           e.id, 32'(end_c),           32'(e.endc));
                chk("valid_out",       e.id, 32'(valid_out),       32'(e.vld));
                chk("pc_out",          e.id, 32'(pc_out),          32'(e.pc));
                chk("instruction_out", e.id, 32'(instruction_out), 32'(exp_ir));
                chk("halted_out",      e.id, 32'(halted_out),      32'(e.hlt));
                chk("error_out",       e.id, 32'(error_out),       32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset_in       = 1'b1;
        stall_in       = 1'b0;
        halt_in        = 1'b0;
        jump_en_in     = 1'b0;
        jump_addr_in   = '0;
        branch_en_in   = 1'b0;
        branch_cond_in = 1'b0;
        branch_addr_in = '0;

        //   rst st hl je ja  be bc ba   endc vld pc irz hlt err
        cyc(1, 0, 0, 0, 0,  0, 0, 0,    0,   0,  0, 1,  0,  0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0,    0,   0,  0, 1,  0,  0);
        // Free-running fetch: pc_out trails end_c by one.
        for (int k = 1; k <= 7; k++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, k, 1, k - 1, 0, 0, 0);
        // Stall three cycles at end_c=7, then a jump to 2 during the stall.
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 6, 0, 0, 0);
        cyc(0, 1, 0, 1, 2,  0, 0, 0,    2,   0,  6, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    3,   1,  2, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    4,   1,  3, 0,  0,  0);
        // Branches at end_c=13.
        cyc(0, 0, 0, 1, 13, 0, 0, 0,    13,  0,  3, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  1, 0, 20,   14,  1, 13, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  1, 1, 20,   20,  0, 13, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    21,  1, 20, 0,  0,  0);
        // Jump and taken branch together: jump wins.
        cyc(0, 0, 0, 1, 11, 1, 1, 20,   11,  0, 20, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    12,  1, 11, 0,  0,  0);
        // Jump to 11 taken at end_c=19.
        cyc(0, 0, 0, 1, 18, 0, 0, 0,    18,  0, 11, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    19,  1, 18, 0,  0,  0);
        cyc(0, 0, 0, 1, 11, 0, 0, 0,    11,  0, 18, 0,  0,  0);
        // halt_in while valid_out=0 is ignored.
        cyc(0, 0, 1, 0, 0,  0, 0, 0,    12,  1, 11, 0,  0,  0);
        // halt_in with valid_out=1 beats stall and jump.
        cyc(0, 1, 1, 1, 5,  0, 0, 0,    12,  0, 11, 0,  1,  0);
        cyc(0, 0, 0, 1, 3,  1, 1, 7,    12,  0, 11, 0,  1,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    12,  0, 11, 0,  1,  0);
        // Reset leaves HALT and overrides every other input.
        cyc(1, 0, 1, 1, 9,  1, 1, 9,    0,   0,  0, 1,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    1,   1,  0, 0,  0,  0);
`ifdef PC_BOUND_CHECK_EN
        // 100 is legal; the sequential step to 101 is not.
        cyc(0, 0, 0, 1, 100, 0, 0, 0,   100, 0,  0, 0,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    100, 0,  0, 0,  1,  1);
        cyc(0, 0, 0, 1, 4,  0, 0, 0,    100, 0,  0, 0,  1,  1);
        cyc(1, 0, 0, 0, 0,  0, 0, 0,    0,   0,  0, 1,  0,  0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    1,   1,  0, 0,  0,  0);
        cyc(0, 0, 0, 1, 101, 0, 0, 0,   1,   0,  0, 0,  1,  1);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    1,   0,  0, 0,  1,  1);
`else
        // Wrap from the top address back to 0.
        cyc(0, 0, 0, 1, 2047, 0, 0, 0,  2047, 0, 0,    0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    0,    1, 2047, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    1,    1, 0,    0, 0, 0);
        // Redirects to out-of-range-looking targets are passed through unchanged.
        cyc(0, 0, 0, 1, 101, 0, 0, 0,   101,  0, 0,    0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0,    102,  1, 101,  0, 0, 0);
`endif
        @(negedge clock_in);
        reset_in     = 1'b0;
        jump_en_in   = 1'b0;
        branch_en_in = 1'b0;
        @(posedge clock_in);
        @(posedge clock_in);
        #2;
        chk("scoreboard_drained", step_no, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
